// File: rtl/read_ptr_ctrl.sv
// Read-side pointer/flag controller for the async FIFO (rclk domain).
// Optional fill-level logic (rd_level, almost_empty) is built when RD_LEVEL_EN is defined.
module read_ptr_ctrl #(
    parameter int Addr_Width = 8,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  r_rst,
    input  logic                  r_en,
    input  logic [Addr_Width:0]   wptr_sync,
    input  logic                  underflow_clr,
    output logic [Addr_Width:0]   raddr,
    output logic [Addr_Width:0]   rptr,
    output logic                  empty,
    output logic                  rd_valid,
    output logic                  underflow,
    output logic [Addr_Width:0]   rd_level,
    output logic                  almost_empty
);
    localparam int PW = Addr_Width + 1;

    logic          rd_acc;
    logic [PW-1:0] raddr_next;
    logic [PW-1:0] rptr_next;

    // Reads are gated by the registered empty, so an underflow attempt never moves a pointer.
    assign rd_acc     = r_en & ~empty;
    assign raddr_next = raddr + {{Addr_Width{1'b0}}, rd_acc};
    assign rptr_next  = (raddr_next >> 1) ^ raddr_next;

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            raddr     <= '0;
            rptr      <= '0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            raddr    <= raddr_next;
            rptr     <= rptr_next;
            empty    <= (rptr_next == wptr_sync);
            rd_valid <= rd_acc;
            if (r_en & empty)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end

`ifdef RD_LEVEL_EN
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    // Gray-to-binary: each bit is the XOR of itself and every more significant Gray bit.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++)
            wbin[i] = ^(wptr_sync >> i);
    end

    assign level_next = wbin - raddr_next;

    always_ff @(posedge rclk) begin
        if (r_rst) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_level     <= level_next;
            almost_empty <= (level_next <= AE_T);
        end
    end
`else
    assign rd_level     = '0;
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Self-checking bench for read_ptr_ctrl (Addr_Width=3, AE_THRESH=2): count-based model plus directed checks.
module tb_read_ptr_ctrl;
    localparam int AW    = 3;
    localparam int AE    = 2;
    localparam int MOD   = 1 << (AW + 1);
`ifdef RD_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic          rclk = 1'b0;
    logic          r_rst;
    logic          r_en;
    logic [AW:0]   wptr_sync;
    logic          underflow_clr;
    logic [AW:0]   raddr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          rd_valid;
    logic          underflow;
    logic [AW:0]   rd_level;
    logic          almost_empty;

    int checks = 0;
    int errors = 0;
    int w_idx  = 0;

    read_ptr_ctrl #(.Addr_Width(AW), .AE_THRESH(AE)) dut (
        .rclk(rclk), .r_rst(r_rst), .r_en(r_en), .wptr_sync(wptr_sync),
        .underflow_clr(underflow_clr), .raddr(raddr), .rptr(rptr), .empty(empty),
        .rd_valid(rd_valid), .underflow(underflow), .rd_level(rd_level),
        .almost_empty(almost_empty)
    );

    // clock / reset block
    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    always_comb wptr_sync = gray(w_idx);

    // Model: a FIFO seen as two counters; everything else follows from their difference.
    bit started = 1'b0;
    int m_rd    = 0;
    int m_lvl   = 0;
    bit m_empty = 1'b1;
    bit m_valid = 1'b0;
    bit m_uf    = 1'b0;

    always @(posedge rclk) begin
        bit acc;
        started = 1'b1;
        if (r_rst) begin
            m_rd = 0; m_lvl = 0; m_empty = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
        end else begin
            acc = r_en && !m_empty;
            if (r_en && m_empty) m_uf = 1'b1;
            else if (underflow_clr) m_uf = 1'b0;
            m_rd    = (m_rd + int'(acc)) % MOD;
            m_valid = acc;
            m_lvl   = (w_idx - m_rd + MOD) % MOD;
            m_empty = (m_lvl == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // scoreboard: compare every output against the model on each falling edge
    always @(negedge rclk) begin
        if (started) begin
            chk("raddr",    int'(raddr),        m_rd);
            chk("rptr",     int'(rptr),         int'(gray(m_rd)));
            chk("empty",    int'(empty),        int'(m_empty));
            chk("rd_valid", int'(rd_valid),     int'(m_valid));
            chk("underflow",int'(underflow),    int'(m_uf));
            chk("rd_level", int'(rd_level),     LVL_EN ? m_lvl : 0);
            chk("almost_empty", int'(almost_empty),
                LVL_EN ? ((m_lvl <= AE) ? 1 : 0) : (r_rst_seen_ae()));
        end
    end

    function automatic int r_rst_seen_ae();
        return 0;
    endfunction

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    function automatic int lv(input int v);
        return LVL_EN ? v : 0;
    endfunction

    initial begin
        r_rst = 1'b1; r_en = 1'b1; underflow_clr = 1'b0; w_idx = 0;

        // reset held with r_en high
        step(2);
        chk("lit_rst_raddr", int'(raddr), 0);
        chk("lit_rst_rptr", int'(rptr), 0);
        chk("lit_rst_empty", int'(empty), 1);
        chk("lit_rst_valid", int'(rd_valid), 0);
        chk("lit_rst_uf", int'(underflow), 0);
        chk("lit_rst_level", int'(rd_level), 0);
        chk("lit_rst_ae", int'(almost_empty), lv(1));

        // drain three words
        r_rst = 1'b0; r_en = 1'b0; w_idx = 3;
        step(1);
        chk("lit_fill_empty", int'(empty), 0);
        chk("lit_fill_level", int'(rd_level), lv(3));
        chk("lit_fill_ae", int'(almost_empty), 0);
        r_en = 1'b1;
        step(1);
        chk("lit_rd1_raddr", int'(raddr), 1);
        chk("lit_rd1_rptr", int'(rptr), 4'b0001);
        chk("lit_rd1_level", int'(rd_level), lv(2));
        chk("lit_rd1_ae", int'(almost_empty), lv(1));
        chk("lit_rd1_valid", int'(rd_valid), 1);
        step(1);
        chk("lit_rd2_rptr", int'(rptr), 4'b0011);
        chk("lit_rd2_level", int'(rd_level), lv(1));
        step(1);
        chk("lit_rd3_raddr", int'(raddr), 3);
        chk("lit_rd3_rptr", int'(rptr), 4'b0010);
        chk("lit_rd3_empty", int'(empty), 1);
        chk("lit_rd3_valid", int'(rd_valid), 1);

        // underflow set, hold, clear, set-over-clear
        step(1);
        chk("lit_uf_raddr", int'(raddr), 3);
        chk("lit_uf_valid", int'(rd_valid), 0);
        chk("lit_uf_set", int'(underflow), 1);
        r_en = 1'b0;
        step(1);
        chk("lit_uf_hold", int'(underflow), 1);
        underflow_clr = 1'b1;
        step(1);
        chk("lit_uf_clr", int'(underflow), 0);
        r_en = 1'b1;
        step(1);
        chk("lit_uf_prio", int'(underflow), 1);
        underflow_clr = 1'b0;

        // wrap: read up to raddr=15, then across the rollover
        w_idx = 15;
        step(13);
        chk("lit_wrap_raddr", int'(raddr), 15);
        chk("lit_wrap_rptr", int'(rptr), 4'b1000);
        chk("lit_wrap_empty", int'(empty), 1);
        r_en = 1'b0; w_idx = 1;
        step(1);
        chk("lit_wrap_level", int'(rd_level), lv(2));
        chk("lit_wrap_ne", int'(empty), 0);
        r_en = 1'b1;
        step(1);
        chk("lit_wrap_r0", int'(raddr), 0);
        chk("lit_wrap_p0", int'(rptr), 0);
        step(1);
        chk("lit_wrap_r1", int'(raddr), 1);
        chk("lit_wrap_p1", int'(rptr), 4'b0001);
        chk("lit_wrap_e", int'(empty), 1);

        // full level from raddr=0
        r_en = 1'b0; r_rst = 1'b1;
        step(1);
        r_rst = 1'b0; w_idx = 8;
        step(1);
        chk("lit_full_level", int'(rd_level), lv(8));
        chk("lit_full_ae", int'(almost_empty), 0);
        chk("lit_full_empty", int'(empty), 0);

        // reset mid-stream with r_en high
        r_en = 1'b1;
        step(3);
        chk("lit_mid_level", int'(rd_level), lv(5));
        r_rst = 1'b1;
        step(1);
        chk("lit_mid_raddr", int'(raddr), 0);
        chk("lit_mid_empty", int'(empty), 1);
        chk("lit_mid_level0", int'(rd_level), 0);
        chk("lit_mid_ae", int'(almost_empty), lv(1));
        chk("lit_mid_valid", int'(rd_valid), 0);
        r_rst = 1'b0; r_en = 1'b0;

        // mixed traffic table: writer never runs more than a full FIFO ahead
        for (int i = 0; i < 48; i++) begin
            if ((i % 3) != 0 && ((w_idx - m_rd + MOD) % MOD) < (1 << AW))
                w_idx = (w_idx + 1) % MOD;
            r_en          = (i % 4) != 1;
            underflow_clr = (i % 7) == 0;
            step(1);
        end
        r_en = 1'b0; underflow_clr = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_ptr_ctrl.md
Name: read_ptr_ctrl

Overview:
Read-side pointer and flag controller for the asynchronous FIFO. It runs in the read clock domain and holds the binary read address that drives the dual-port memory. It also holds the Gray-coded read pointer that is synchronised into the write domain. Registered empty, almost-empty, fill-level, read-valid and sticky underflow outputs are derived from the write pointer after it has been synchronised into this domain.

Parameters:
Addr_Width, 8, memory address width; FIFO depth = 2**Addr_Width; all pointers are Addr_Width+1 bits.
AE_THRESH, 2, almost_empty asserts when fill level <= AE_THRESH (legal range 0..2**Addr_Width-1).

Ports:
rclk  input  1  read-domain clock; all state updates on its rising edge.
r_rst  input  1  synchronous, active-high reset.
r_en  input  1  read request from the consumer.
wptr_sync  input  Addr_Width+1  Gray write pointer, already 2-flop synchronised into rclk.
underflow_clr  input  1  clears the sticky underflow flag.
raddr  output  Addr_Width+1  binary read pointer; memory uses raddr[Addr_Width-1:0].
rptr  output  Addr_Width+1  Gray read pointer, registered, sent to write-domain synchroniser.
empty  output  1  registered empty flag.
rd_valid  output  1  one-cycle pulse, cycle after an accepted read (1-cycle memory latency).
underflow  output  1  sticky flag: a read was attempted while empty.
rd_level  output  Addr_Width+1  registered fill level, 0..2**Addr_Width.
almost_empty  output  1  registered; rd_level <= AE_THRESH.

Behaviour:
- Reset (r_rst=1 at a rclk edge): raddr=0, rptr=0, empty=1, rd_valid=0, underflow=0, rd_level=0, almost_empty=1. Reset overrides all other inputs, including mid-stream.
- Read acceptance: rd_acc = r_en & !empty, using the registered empty.
- raddr_next = raddr + rd_acc (modulo 2**(Addr_Width+1)).
- rptr_next = (raddr_next >> 1) ^ raddr_next.
- Both raddr and rptr register their _next values every cycle.
- empty <= (rptr_next == wptr_sync).
  - Empty asserts on the same edge as the read that consumes the last word.
  - Empty deasserts the first edge after wptr_sync moves away from rptr.
- rd_valid <= rd_acc.
- underflow:
  - Set when r_en & empty.
  - Cleared when underflow_clr=1 and no new underflow occurs in that cycle; set has priority over clear.
  - The pointers do not move on an underflow attempt.
- Write-pointer conversion: wbin = Gray-to-binary of wptr_sync (prefix XOR from MSB), combinational.
- rd_level <= wbin - raddr_next, computed in Addr_Width+1 bits (wrap-safe modulo arithmetic). Maximum 2**Addr_Width when full.
- almost_empty <= (wbin - raddr_next) <= AE_THRESH.
- Wrap-around: raddr rolls over from 2**(Addr_Width+1)-1 to 0. The MSB toggles every pass through memory. Level and empty stay correct across the wrap.
- Consecutive reads at one per cycle are supported until empty.

Optional Feature:
Macro RD_LEVEL_EN.
- Defined: the wbin conversion, rd_level and almost_empty logic are built as described above.
- Undefined: that logic is omitted and the outputs are tied to constants: rd_level=0, almost_empty=0.
- raddr, rptr, empty, rd_valid and underflow behave identically in both builds. The port list is unchanged.

Test Plan:
All scenarios use Addr_Width=3, AE_THRESH=2, RD_LEVEL_EN defined, except where stated.
1. Reset: hold r_rst=1 for 2 cycles with r_en=1 -> raddr=0, rptr=0000, empty=1, rd_valid=0, underflow=0, rd_level=0, almost_empty=1.
2. Drain: set wptr_sync=0010 (bin 3) -> next edge empty=0, rd_level=3, almost_empty=0. Then r_en=1 for 3 cycles:
   - raddr 1,2,3 and rptr 0001,0011,0010.
   - rd_level 2,1,0; almost_empty=1 from the first read.
   - empty=1 on the third edge; rd_valid high for the 3 cycles following each accepted read.
3. Underflow: r_en=1 while empty=1 -> raddr unchanged, rd_valid=0, underflow=1 and held. Then underflow_clr=1 with r_en=0 -> underflow=0. underflow_clr=1 with r_en=1 while empty -> underflow stays 1.
4. Wrap: advance wptr_sync and read until raddr=15 (rptr 1000). Set wptr_sync=Gray(17)=11001? That exceeds 4 bits; use Gray(1)=0001 instead -> rd_level=2. Two reads -> raddr 0 then 1, rptr 0000 then 0001, empty=1.
5. Full level: raddr=0, wptr_sync=Gray(8)=1100 -> rd_level=8, almost_empty=0, empty=0.
6. Reset mid-stream / macro off:
   - Mid-stream: with rd_level=5, assert r_rst together with r_en=1 -> all outputs return to their reset values on that edge.
   - Macro off: rebuild without RD_LEVEL_EN and repeat scenario 2 -> identical raddr, rptr, empty and rd_valid; rd_level=0 and almost_empty=0 throughout.
